// File: rtl/sd_blk_responder.sv
// Block-transfer responder: services one 512-byte read or write request per
// level request, moving bytes between an initiator buffer and an image memory.
module sd_blk_responder #(
  parameter int MEM_AW = 24
) (
  input  logic              sd_clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic [31:0]       img_blocks,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  input  logic              mem_ready,
  output logic [15:0]       blk_count
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE
  } state_t;

  state_t            state;
  logic [8:0]        offset;
  logic [MEM_AW-10:0] lba_q;
  logic              in_range;
  logic              req_in_range;

  assign req_in_range = (sd_lba < img_blocks);

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state        <= IDLE;
      offset       <= '0;
      lba_q        <= '0;
      in_range     <= 1'b0;
      sd_ack       <= 1'b0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_dout     <= '0;
      blk_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            lba_q    <= sd_lba[MEM_AW-10:0];
            in_range <= req_in_range;
            offset   <= '0;
            sd_ack   <= 1'b1;
            mem_addr <= {sd_lba[MEM_AW-10:0], 9'd0};
            if (sd_rd) begin
              // mem_rd is raised on entry so it is a clean register output in RD_REQ
              mem_rd <= req_in_range;
              state  <= RD_REQ;
            end else begin
              sd_buff_addr <= '0;
              state        <= WR_ADDR;
            end
          end
        end
        RD_REQ: begin
          if (!in_range || mem_ready) begin
            sd_buff_dout <= in_range ? mem_din : 8'h00;
            sd_buff_addr <= offset;
            sd_buff_wr   <= 1'b1;
            mem_rd       <= 1'b0;
            state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          sd_buff_wr <= 1'b0;
          if (offset == 9'd511) begin
            sd_ack    <= 1'b0;
            blk_count <= blk_count + 16'd1;
            state     <= DONE;
          end else begin
            offset   <= offset + 9'd1;
            mem_addr <= {lba_q, offset + 9'd1};
            mem_rd   <= in_range;
            state    <= RD_REQ;
          end
        end
        WR_ADDR: state <= WR_CAP;
        WR_CAP: begin
          mem_dout <= sd_buff_din;
          mem_addr <= {lba_q, offset};
          mem_wr   <= in_range;
          state    <= WR_MEM;
        end
        WR_MEM: begin
          if (!in_range || mem_ready) begin
            mem_wr <= 1'b0;
            if (offset == 9'd511) begin
              sd_ack    <= 1'b0;
              blk_count <= blk_count + 16'd1;
              state     <= DONE;
            end else begin
              offset       <= offset + 9'd1;
              sd_buff_addr <= offset + 9'd1;
              state        <= WR_ADDR;
            end
          end
        end
        DONE: begin
          if (!sd_rd && !sd_wr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_blk_responder.sv
// Randomized self-checking bench for sd_blk_responder against a byte-level
// model of the image memory and the initiator buffer.
module tb_sd_blk_responder;
  localparam int MEM_AW = 24;

  logic              sd_clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       sd_lba = '0;
  logic              sd_rd = 1'b0;
  logic              sd_wr = 1'b0;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = '0;
  logic [31:0]       img_blocks = 32'd100;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = '0;
  logic              mem_ready = 1'b0;
  logic [15:0]       blk_count;

  sd_blk_responder #(.MEM_AW(MEM_AW)) dut (
    .sd_clk(sd_clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_blocks(img_blocks),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready), .blk_count(blk_count)
  );

  initial forever #5 sd_clk = ~sd_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Image memory model: unwritten bytes read back as the low address byte.
  logic [7:0] mem_model [int unsigned];
  logic [7:0] ram [512];

  function automatic logic [7:0] mem_peek(input int unsigned a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0];
  endfunction

  function automatic int unsigned blk_base(input logic [31:0] lba);
    return (lba % (32'd1 << (MEM_AW - 9))) * 512;
  endfunction

  int strobes, rd_errs, ord_errs, rd_cycles, wr_done, addr_errs, stab_errs, ovl_errs;
  logic [31:0] cur_lba = '0;
  bit cur_inr;
  int stall_max = 0;
  bit tie_ready = 1'b0;
  int exp_blk = 0;

  task automatic clear_counts();
    strobes = 0; rd_errs = 0; ord_errs = 0; rd_cycles = 0;
    wr_done = 0; addr_errs = 0; stab_errs = 0; ovl_errs = 0;
  endtask

  // Initiator buffer (registered RAM) and strobe monitor.
  initial begin
    logic [8:0] prev_baddr;
    logic [7:0] exp;
    prev_baddr = '0;
    forever begin
      @(negedge sd_clk);
      sd_buff_din = ram[prev_baddr];
      prev_baddr  = sd_buff_addr;
      if (mem_rd && mem_wr) ovl_errs++;
      if (mem_rd) rd_cycles++;
      if (sd_buff_wr) begin
        if (sd_buff_addr != strobes[8:0]) ord_errs++;
        exp = cur_inr ? mem_peek(blk_base(cur_lba) + sd_buff_addr) : 8'h00;
        if (sd_buff_dout !== exp) rd_errs++;
        strobes++;
      end
    end
  end

  // Image memory responder with random stalls.
  initial begin
    bit in_req;
    int stall;
    logic [MEM_AW-1:0] s_addr;
    logic [7:0] s_dout;
    in_req = 1'b0; stall = 0; s_addr = '0; s_dout = '0;
    forever begin
      @(negedge sd_clk);
      mem_din = mem_peek(int'(mem_addr));
      if (mem_rd || mem_wr) begin
        if (!in_req) begin
          in_req = 1'b1;
          stall  = tie_ready ? 0 : int'($urandom_range(stall_max, 0));
          s_addr = mem_addr;
          s_dout = mem_dout;
        end else if (mem_addr !== s_addr || (mem_wr && mem_dout !== s_dout)) begin
          stab_errs++;
        end
        if (stall == 0) begin
          mem_ready = 1'b1;
          in_req    = 1'b0;
          if (int'(mem_addr) / 512 != blk_base(cur_lba) / 512) addr_errs++;
          if (mem_wr) begin
            if (mem_addr[8:0] != wr_done[8:0]) addr_errs++;
            if (!reset) begin
              mem_model[int'(mem_addr)] = mem_dout;
              wr_done++;
            end
          end else if (mem_addr[8:0] != strobes[8:0]) begin
            addr_errs++;
          end
        end else begin
          stall--;
          mem_ready = tie_ready;
        end
      end else begin
        in_req    = 1'b0;
        mem_ready = tie_ready;
      end
    end
  end

  task automatic wait_block(output int cyc);
    bit saw;
    saw = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge sd_clk);
      cyc++;
      if (cyc == 5) sd_lba = $urandom;
      if (sd_ack) saw = 1'b1;
      else if (saw) return;
    end
    check_eq("block_done", 32'd0, 32'd1);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] lba, input int from, input int to);
    int e;
    e = 0;
    for (int k = from; k < to; k++)
      if (mem_peek(blk_base(lba) + k) !== ram[k]) e++;
    check_eq(tag, e, 0);
  endtask

  task automatic run_block(input bit is_rd, input bit both, input logic [31:0] lba,
                           input int smax, input bit tie, input int exp_lat, input int hold);
    int cyc, extra;
    @(negedge sd_clk);
    clear_counts();
    cur_lba = lba; cur_inr = (lba < img_blocks);
    stall_max = smax; tie_ready = tie;
    sd_lba = lba;
    sd_rd = is_rd;
    sd_wr = !is_rd || both;
    wait_block(cyc);
    exp_blk++;
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge sd_clk);
      if (sd_ack || sd_buff_wr || mem_rd || mem_wr) extra++;
    end
    if (hold != 0) check_eq("no_retrigger", extra, 0);
    check_eq(is_rd ? "rd_strobes" : "wr_strobes", strobes, is_rd ? 512 : 0);
    if (is_rd) begin
      check_eq("rd_data", rd_errs, 0);
      check_eq("rd_order", ord_errs, 0);
    end
    if (!cur_inr) check_eq("oor_mem_rd", rd_cycles, 0);
    check_eq("wr_completions", wr_done, (!is_rd && cur_inr) ? 512 : 0);
    if (!is_rd && cur_inr) check_mem("wr_data", lba, 0, 512);
    check_eq("mem_addr_seq", addr_errs, 0);
    check_eq("mem_stable", stab_errs, 0);
    check_eq("rd_wr_overlap", ovl_errs, 0);
    if (exp_lat != 0) check_eq("latency", cyc, exp_lat);
    check_eq("blk_count", blk_count, exp_blk);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
  endtask

  initial begin
    int got300;
    repeat (3) @(negedge sd_clk);
    check_eq("rst_ctrl", {sd_ack, sd_buff_wr, mem_rd, mem_wr}, 0);
    check_eq("rst_buff_addr", sd_buff_addr, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_blk_count", blk_count, 0);
    reset = 1'b0;

    // Directed read and write with memory always ready.
    run_block(1'b1, 1'b0, 32'd5, 0, 1'b1, 1025, 0);
    for (int k = 0; k < 512; k++) ram[k] = 8'(~k);
    run_block(1'b0, 1'b0, 32'd3, 0, 1'b1, 1537, 0);

    // Stalled memory: read back the block just written, then a random block.
    run_block(1'b1, 1'b0, 32'd3, 7, 1'b0, 0, 0);
    for (int k = 0; k < 512; k++) ram[k] = 8'($urandom);
    run_block(1'b0, 1'b0, 32'd42, 7, 1'b0, 0, 0);
    run_block(1'b1, 1'b0, 32'd42, 7, 1'b0, 0, 0);

    // Out-of-range block on both directions.
    run_block(1'b1, 1'b0, 32'd200, 3, 1'b0, 1025, 0);
    run_block(1'b0, 1'b0, 32'd200, 3, 1'b0, 1537, 0);

    // Simultaneous requests favour read; a held request does not retrigger.
    run_block(1'b1, 1'b1, 32'd9, 2, 1'b0, 0, 20);

    // Reset in the middle of a write.
    for (int k = 0; k < 512; k++) ram[k] = 8'($urandom);
    @(negedge sd_clk);
    clear_counts();
    cur_lba = 32'd7; cur_inr = 1'b1; stall_max = 3; tie_ready = 1'b0;
    sd_lba = 32'd7; sd_wr = 1'b1;
    got300 = 0;
    for (int i = 0; i < 20000 && got300 == 0; i++) begin
      @(negedge sd_clk);
      if (sd_ack && sd_buff_addr == 9'd300) got300 = 1;
    end
    check_eq("reach_offset_300", got300, 1);
    reset = 1'b1;
    @(negedge sd_clk);
    check_eq("midrst_ctrl", {sd_ack, sd_buff_wr, mem_rd, mem_wr}, 0);
    check_eq("midrst_buff_addr", sd_buff_addr, 0);
    check_eq("midrst_buff_dout", sd_buff_dout, 0);
    check_eq("midrst_mem_addr", mem_addr, 0);
    check_eq("midrst_mem_dout", mem_dout, 0);
    check_eq("midrst_blk_count", blk_count, 0);
    check_eq("midrst_wr_completions", wr_done, 300);
    check_mem("midrst_low_written", 32'd7, 0, 300);
    begin
      int e;
      e = 0;
      for (int k = 300; k < 512; k++)
        if (mem_model.exists(blk_base(32'd7) + k)) e++;
      check_eq("midrst_high_untouched", e, 0);
    end
    exp_blk = 0;
    wr_done = 0;
    reset = 1'b0;
    @(negedge sd_clk);
    check_eq("req_after_reset", sd_ack, 1'b1);
    begin
      int cyc;
      wait_block(cyc);
    end
    exp_blk++;
    check_eq("post_rst_wr_completions", wr_done, 512);
    check_mem("post_rst_wr_data", 32'd7, 0, 512);
    check_eq("post_rst_blk_count", blk_count, exp_blk);
    sd_wr = 1'b0;

    // Random mix of reads and writes, some out of range.
    for (int t = 0; t < 4; t++) begin
      bit rd;
      logic [31:0] lba;
      rd  = 1'($urandom);
      lba = $urandom_range(149, 0);
      for (int k = 0; k < 512; k++) ram[k] = 8'($urandom);
      run_block(rd, 1'b0, lba, 7, 1'b0, 0, 0);
    end

    repeat (4) @(negedge sd_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
